// File: rtl/exec_commit_unit.sv
// exec_commit_unit
// Commits the execute-stage bundle coming out of the ALU. Register writes are
// offered to the register file with a valid/ready handshake. Taken branches
// raise a PC redirect. The next FLUSH_SLOTS accepted bundles after a taken
// branch are wrong-path instructions and are discarded.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_ready   handshake for the execute bundle
//   OpCode, RdOut,      execute bundle fields. AluResult[0] is the BEG
//   branchResult,       condition.
//   AluResult
//   wr_en/wr_ready,     register-file write request. It is held until
//   wr_addr, wr_data    wr_ready is seen.
//   pc_load, pc_target  one-cycle redirect pulse and redirect address
//   illegal_op          one-cycle pulse when opcode 11..31 is committed
//   retire_count        legal instructions committed (saturating)
//   squash_count        wrong-path instructions discarded (saturating)

module exec_commit_unit #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 7,
  parameter int PC_W        = 7,
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        OpCode,
  input  logic [REG_W-1:0]  RdOut,
  input  logic [PC_W-1:0]   branchResult,
  input  logic [DATA_W-1:0] AluResult,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [REG_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CNT_W-1:0]  squash_count
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_SLOTS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  logic [3:0] cnt;

  logic accept;
  logic is_write;
  logic is_branch;
  logic is_illegal;

  // A pending write blocks new bundles. The exception is the cycle in which
  // the write drains, so back-to-back writes flow without a bubble.
  assign in_ready = !wr_en || wr_ready;
  assign accept   = in_valid && in_ready;

  // Decode the opcode class. BEG counts as a branch only when its condition
  // bit is set. When the condition is clear it behaves like a NOP.
  always_comb begin
    is_write   = 1'b0;
    is_branch  = 1'b0;
    is_illegal = 1'b0;
    case (OpCode)
      5'd0:                                            ;
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10: is_write   = 1'b1;
      5'd7:                                            is_branch  = 1'b1;
      5'd8:                                            is_branch  = AluResult[0];
      default:                                         is_illegal = 1'b1;
    endcase
  end

  // Commit state machine. RUN commits bundles. FLUSH discards a fixed number
  // of accepted bundles after a taken branch and counts each one as squashed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      pc_load      <= 1'b0;
      pc_target    <= '0;
      illegal_op   <= 1'b0;
      retire_count <= '0;
      squash_count <= '0;
    end else begin
      pc_load    <= 1'b0;
      illegal_op <= 1'b0;

      if (wr_en && wr_ready)
        wr_en <= 1'b0;

      if (accept) begin
        if (state == FLUSH) begin
          if (!(&squash_count))
            squash_count <= squash_count + CNT_ONE;
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1)
            state <= RUN;
        end else if (is_illegal) begin
          illegal_op <= 1'b1;
        end else begin
          if (!(&retire_count))
            retire_count <= retire_count + CNT_ONE;
          if (is_write) begin
            wr_en   <= 1'b1;
            wr_addr <= RdOut;
            wr_data <= AluResult;
          end
          if (is_branch) begin
            pc_load   <= 1'b1;
            pc_target <= branchResult;
            state     <= FLUSH;
            cnt       <= FLUSH_INIT;
          end
        end
      end
    end
  end

endmodule
